// File: rtl/raster_timing_gen.sv
// raster_timing_gen: raster scan counters, compositor strobe and registered display pins
module raster_timing_gen #(
  parameter int unsigned H_ACTIVE   = 640,
  parameter int unsigned H_FP       = 16,
  parameter int unsigned H_SYNC     = 96,
  parameter int unsigned H_BP       = 48,
  parameter int unsigned V_ACTIVE   = 480,
  parameter int unsigned V_FP       = 10,
  parameter int unsigned V_SYNC     = 2,
  parameter int unsigned V_BP       = 33,
  parameter bit          H_SYNC_POL = 1'b0,
  parameter bit          V_SYNC_POL = 1'b0,
  parameter logic [23:0] BG_COLOR   = 24'h000000
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_pix_ce,
  output logic [15:0] o_x,
  output logic [15:0] o_y,
  output logic        o_v_sync,
  input  logic [7:0]  i_red,
  input  logic [7:0]  i_green,
  input  logic [7:0]  i_blue,
  input  logic        i_sprite_hit,
  output logic        o_hsync,
  output logic        o_vsync,
  output logic        o_de,
  output logic [7:0]  o_red,
  output logic [7:0]  o_green,
  output logic [7:0]  o_blue,
  output logic [15:0] o_frame
);
  localparam logic [15:0] HA  = 16'(H_ACTIVE);
  localparam logic [15:0] HS0 = 16'(H_ACTIVE + H_FP);
  localparam logic [15:0] HS1 = 16'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [15:0] HT1 = 16'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
  localparam logic [15:0] VA  = 16'(V_ACTIVE);
  localparam logic [15:0] VS0 = 16'(V_ACTIVE + V_FP);
  localparam logic [15:0] VS1 = 16'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [15:0] VT1 = 16'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);
  logic [15:0] h_q, h_d, v_q, v_d, frame_q, frame_d;
  logic        de_q, de_d, hs_q, hs_d, vs_q, vs_d;
  logic [23:0] rgb_q, rgb_d;
  logic        act, h_end, v_end;
  // next counters and display pins, decoded from the pre-increment position
  always_comb begin
    h_end   = h_q == HT1;
    v_end   = v_q == VT1;
    act     = h_q < HA && v_q < VA;
    h_d     = i_pix_ce ? (h_end ? '0 : h_q + 16'd1) : h_q;
    v_d     = i_pix_ce && h_end ? (v_end ? '0 : v_q + 16'd1) : v_q;
    frame_d = i_pix_ce && h_end && v_end ? frame_q + 16'd1 : frame_q;
    de_d    = i_pix_ce ? act : de_q;
    hs_d    = i_pix_ce ? ((h_q >= HS0 && h_q < HS1) == H_SYNC_POL) : hs_q;
    vs_d    = i_pix_ce ? ((v_q >= VS0 && v_q < VS1) == V_SYNC_POL) : vs_q;
    rgb_d   = i_pix_ce ? (act ? (i_sprite_hit ? {i_red, i_green, i_blue} : BG_COLOR) : '0) : rgb_q;
  end
  // state registers; reset wins over the pixel enable
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      h_q     <= '0;
      v_q     <= '0;
      frame_q <= '0;
      de_q    <= 1'b0;
      hs_q    <= !H_SYNC_POL;
      vs_q    <= !V_SYNC_POL;
      rgb_q   <= '0;
    end else begin
      h_q     <= h_d;
      v_q     <= v_d;
      frame_q <= frame_d;
      de_q    <= de_d;
      hs_q    <= hs_d;
      vs_q    <= vs_d;
      rgb_q   <= rgb_d;
    end
  end
  assign o_x      = h_q;
  assign o_y      = v_q;
  assign o_v_sync = h_q == '0 && v_q == VA;
  assign o_hsync  = hs_q;
  assign o_vsync  = vs_q;
  assign o_de     = de_q;
  assign {o_red, o_green, o_blue} = rgb_q;
  assign o_frame  = frame_q;
endmodule

// File: tb/tb_raster_timing_gen.sv
// tb_raster_timing_gen: scoreboard bench for raster_timing_gen on a 16x8 raster plus polarity instances
module tb_raster_timing_gen;
  localparam logic [23:0] BG = 24'hA5C3E7;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst = 1'b1, ce = 1'b0, hit = 1'b0;
  logic [23:0] col = '0;
  logic [15:0] x, y, frame;
  logic vsy, hs, vs, de;
  logic [7:0] r, g, b;
  logic rst2 = 1'b1;
  logic [15:0] x6, y6, f6, x7, y7, f7;
  logic vsy6, hs6, vs6, de6, vsy7, hs7, vs7, de7;
  logic [7:0] r6, g6, b6, r7, g7, b7;
  raster_timing_gen #(.H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(3), .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1),
    .H_SYNC_POL(1'b0), .V_SYNC_POL(1'b0), .BG_COLOR(BG)) dut (
    .i_clk(clk), .i_rst(rst), .i_pix_ce(ce), .o_x(x), .o_y(y), .o_v_sync(vsy),
    .i_red(col[23:16]), .i_green(col[15:8]), .i_blue(col[7:0]), .i_sprite_hit(hit),
    .o_hsync(hs), .o_vsync(vs), .o_de(de), .o_red(r), .o_green(g), .o_blue(b), .o_frame(frame));
  raster_timing_gen #(.H_SYNC_POL(1'b1), .V_SYNC_POL(1'b1)) u6 (
    .i_clk(clk), .i_rst(rst2), .i_pix_ce(1'b1), .o_x(x6), .o_y(y6), .o_v_sync(vsy6),
    .i_red(8'h00), .i_green(8'h00), .i_blue(8'h00), .i_sprite_hit(1'b0),
    .o_hsync(hs6), .o_vsync(vs6), .o_de(de6), .o_red(r6), .o_green(g6), .o_blue(b6), .o_frame(f6));
  raster_timing_gen #(.H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(3), .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1),
    .H_SYNC_POL(1'b1), .V_SYNC_POL(1'b1)) u7 (
    .i_clk(clk), .i_rst(rst2), .i_pix_ce(1'b1), .o_x(x7), .o_y(y7), .o_v_sync(vsy7),
    .i_red(8'h00), .i_green(8'h00), .i_blue(8'h00), .i_sprite_hit(1'b0),
    .o_hsync(hs7), .o_vsync(vs7), .o_de(de7), .o_red(r7), .o_green(g7), .o_blue(b7), .o_frame(f7));
  typedef struct {string name; logic [75:0] v;} exp_t;
  exp_t q[$];
  exp_t e;
  int checks = 0, failures = 0;
  int p = 0, fr = 0;
  logic m_de = 1'b0, m_hs = 1'b1, m_vs = 1'b1;
  logic [23:0] m_rgb = '0;
  function automatic logic [75:0] pk(logic [15:0] px, logic [15:0] py, logic [15:0] pf, logic pde, logic phs,
                                     logic pvs, logic pvsy, logic [23:0] prgb);
    return {px, py, pf, pde, phs, pvs, pvsy, prgb};
  endfunction
  task automatic chk(string n, logic [75:0] a, logic [75:0] x_e);
    checks++;
    if (a !== x_e) begin
      failures++;
      $display("FAIL %s actual={x,y,frame,de,hs,vs,vsync,rgb}=%h required=%h", n, a, x_e);
    end
  endtask
  task automatic chk_int(string n, int a, int x_e);
    checks++;
    if (a != x_e) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", n, a, x_e);
    end
  endtask
  // model: linear pixel index in the 16x8 frame; display pins reflect the pixel just consumed
  task automatic step(bit c, bit r_, bit h_, logic [23:0] cl, string nm);
    int hh, vv;
    ce = c; rst = r_; hit = h_; col = cl;
    @(posedge clk); #1;
    if (r_) begin
      p = 0; fr = 0; m_de = 1'b0; m_hs = 1'b1; m_vs = 1'b1; m_rgb = '0;
    end else if (c) begin
      hh = p % 16; vv = p / 16;
      m_de = hh < 8 && vv < 4;
      m_hs = !(hh >= 10 && hh < 13);
      m_vs = !(vv >= 5 && vv < 7);
      m_rgb = m_de ? (h_ ? cl : BG) : 24'h0;
      p = (p + 1) % 128;
      if (p == 0) fr++;
    end
    q.push_back('{nm, pk(16'(p % 16), 16'(p / 16), 16'(fr), m_de, m_hs, m_vs, p == 64, m_rgb)});
  endtask
  // monitor: compare every queued expectation against the live outputs
  always @(negedge clk) begin
    while (q.size() > 0) begin
      e = q.pop_front();
      chk(e.name, pk(x, y, frame, de, hs, vs, vsy, {r, g, b}), e.v);
    end
  end
  initial begin
    int hh, vv, hs_low, vs_low, vs_hi, bad, hi, h6;
    bit hb;
    logic [23:0] cl;
    step(0, 1, 0, 24'h0, "reset");
    step(1, 1, 1, 24'hFFFFFF, "reset_over_ce");
    q.push_back('{"reset_state", pk(16'd0, 16'd0, 16'd0, 1'b0, 1'b1, 1'b1, 1'b0, 24'h0)});
    hs_low = 0; vs_low = 0;
    for (int k = 0; k < 128; k++) begin
      hh = p % 16; vv = p / 16;
      hb = (vv == 1 && (hh == 2 || hh == 9)) ? 1'b1 : (vv == 1 && hh == 3) ? 1'b0 : 1'($urandom_range(0, 1));
      cl = (hh == 2) ? 24'h112233 : (hh == 9) ? 24'hABCDEF : 24'($urandom);
      step(1, 0, hb, cl, "t1_run");
      if (hs === 1'b0) hs_low++;
      if (vs === 1'b0) vs_low++;
      if (hh == 2 && vv == 1) q.push_back('{"t2_hit", pk(16'd3, 16'd1, 16'd0, 1'b1, 1'b1, 1'b1, 1'b0, 24'h112233)});
      if (hh == 3 && vv == 1) q.push_back('{"t2_bg", pk(16'd4, 16'd1, 16'd0, 1'b1, 1'b1, 1'b1, 1'b0, BG)});
      if (hh == 9 && vv == 1) q.push_back('{"t2_blank", pk(16'd10, 16'd1, 16'd0, 1'b0, 1'b1, 1'b1, 1'b0, 24'h0)});
    end
    chk_int("t1_hsync_low_clks", hs_low, 24);
    chk_int("t1_vsync_low_clks", vs_low, 32);
    q.push_back('{"t1_frame_wrap", pk(16'd0, 16'd0, 16'd1, 1'b0, 1'b1, 1'b1, 1'b0, 24'h0)});
    step(0, 1, 0, 24'h0, "t3_reset");
    hs_low = 0;
    for (int k = 0; k < 32; k++) begin
      step(k % 2 == 0, 0, 1'($urandom_range(0, 1)), 24'($urandom), "t3_toggle");
      if (hs === 1'b0) hs_low++;
    end
    chk_int("t3_hsync_low_clks", hs_low, 6);
    step(0, 1, 0, 24'h0, "t4_reset");
    vs_hi = 0;
    for (int k = 0; k < 384; k++) begin
      step(1, 0, 1'($urandom_range(0, 1)), 24'($urandom), "t4_frames");
      if (vsy === 1'b1) vs_hi++;
    end
    chk_int("t4_vsync_strobes", vs_hi, 3);
    q.push_back('{"t4_frame3", pk(16'd0, 16'd0, 16'd3, 1'b0, 1'b1, 1'b1, 1'b0, 24'h0)});
    for (int k = 0; k < 37; k++) step(1, 0, 1'b1, 24'h445566, "t5_run");
    step(1, 1, 1, 24'hFFFFFF, "t5_reset");
    q.push_back('{"t5_reset_mid", pk(16'd0, 16'd0, 16'd0, 1'b0, 1'b1, 1'b1, 1'b0, 24'h0)});
    chk_int("t6_reset_hs_vs", {hs6, vs6, hs7, vs7}, 0);
    rst2 = 1'b0;
    bad = 0; hi = 0;
    for (int k = 1; k <= 800; k++) begin
      @(posedge clk); #1;
      h6 = k - 1;
      if (hs6 !== (h6 >= 656 && h6 < 752)) bad++;
      if (hs6 === 1'b1) hi++;
      if (vs6 !== 1'b0) bad++;
      if (k <= 128) begin
        hh = (k - 1) % 16; vv = (k - 1) / 16;
        if (vs7 !== (vv == 5 || vv == 6)) bad++;
        if (hs7 !== (hh >= 10 && hh < 13)) bad++;
        if (vs7 === 1'b1) vs_hi++;
      end
    end
    chk_int("t6_pol_mismatches", bad, 0);
    chk_int("t6_hsync_high_clks", hi, 96);
    chk_int("t6_vsync_high_clks", vs_hi - 3, 32);
    repeat (2) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
